limn2600_bus_arbiter: RTL and testbench

LIMN2600_BUS_ARBITER -- requirements
Module: limn2600_bus_arbiter

---
 rtl/limn2600_bus_pkg.sv | 27 ++
 rtl/limn2600_bus_arbiter_if.sv | 48 ++++
 rtl/limn2600_rr_arbiter.sv | 36 +++
 rtl/limn2600_bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_limn2600_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/limn2600_bus_pkg.sv
// Shared definitions for the LIMN2600 bus arbiter: FSM encoding, the
// slave-select field inside the address, and fixed internal widths.
package limn2600_bus_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } arb_state_e;

    // Slave select is the top SEL_W bits of the address.
    localparam int SEL_W = 4;

    // Round-robin pointer / grant index width (covers up to 8 masters).
    localparam int PTR_W = 3;

    // Timeout counter width (covers TIMEOUT up to 65535).
    localparam int CNT_W = 16;

    // Bit position of the slave-select field for a given address width.
    function automatic int sel_lsb(input int addr_w);
        return addr_w - SEL_W;
    endfunction

endpackage

// File: rtl/limn2600_bus_arbiter_if.sv
// Bundle of all master-side and slave-side bus signals around the arbiter.
//
// Handshake: a master raises m_cs with m_we/m_addr/m_wdata and holds them
// until it sees its m_rdy bit pulse for one cycle (m_err alongside on a bus
// error; m_rdata is valid in that same cycle). The arbiter holds one s_cs bit
// with s_we/s_addr/s_wdata stable until the selected slave raises its s_rdy
// bit (s_rdata valid in that cycle) or the timeout expires.
interface limn2600_bus_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    logic [N_MASTERS-1:0]        m_cs;
    logic [N_MASTERS-1:0]        m_we;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0]           m_rdata;
    logic [N_MASTERS-1:0]        m_rdy;
    logic [N_MASTERS-1:0]        m_err;

    logic [N_SLAVES-1:0]         s_cs;
    logic                        s_we;
    logic [ADDR_W-1:0]           s_addr;
    logic [DATA_W-1:0]           s_wdata;
    logic [N_SLAVES*DATA_W-1:0]  s_rdata;
    logic [N_SLAVES-1:0]         s_rdy;

    // View of the requesting masters.
    modport master (
        output m_cs, m_we, m_addr, m_wdata,
        input  m_rdata, m_rdy, m_err
    );

    // View of the decoded slaves.
    modport slave (
        input  s_cs, s_we, s_addr, s_wdata,
        output s_rdata, s_rdy
    );

    // View of the arbiter sitting between both sides.
    modport arbiter (
        input  m_cs, m_we, m_addr, m_wdata,
        output m_rdata, m_rdy, m_err,
        output s_cs, s_we, s_addr, s_wdata,
        input  s_rdata, s_rdy
    );
endinterface

// File: rtl/limn2600_rr_arbiter.sv
// Combinational round-robin selector: the first requester at or after the
// pointer wins, wrapping around to index 0.
module limn2600_rr_arbiter
    import limn2600_bus_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    // Two passes: indices at/after the pointer first, then the wrapped ones.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!valid_o && req_i[j] && (j >= int'(ptr_i))) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PTR_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!valid_o && req_i[j] && (j < int'(ptr_i))) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/limn2600_bus_arbiter.sv
// Multi-master / multi-slave bus arbiter. One transaction at a time:
// round-robin grant, address decode on the top address bits, slave wait
// with timeout, and a one-cycle ready (plus error) pulse back to the master.
// Every bus output comes straight from a register.
module limn2600_bus_arbiter
    import limn2600_bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    limn2600_bus_arbiter_if.arbiter bus,
    output arb_state_e              dbg_state_o,
    output logic [PTR_W-1:0]        dbg_ptr_o
);

    localparam int              SEL_LSB  = sel_lsb(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e              state_q, state_d;
    logic [N_MASTERS-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]        gidx_q, gidx_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_SLAVES-1:0]     s_cs_q, s_cs_d;
    logic                    s_we_q, s_we_d;
    logic [ADDR_W-1:0]       s_addr_q, s_addr_d;
    logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
    logic [N_MASTERS-1:0]    m_rdy_q, m_rdy_d;
    logic [N_MASTERS-1:0]    m_err_q, m_err_d;

    logic [N_MASTERS-1:0]    rr_grant;
    logic [PTR_W-1:0]        rr_idx;
    logic                    rr_valid;

    logic                    req_we;
    logic [ADDR_W-1:0]       req_addr;
    logic [DATA_W-1:0]       req_wdata;
    logic [SEL_W-1:0]        req_sel;
    logic                    req_mapped;

    logic [DATA_W-1:0]       rd_data;
    logic                    rd_hit;
    logic [PTR_W-1:0]        ptr_next;

    limn2600_rr_arbiter #(
        .N (N_MASTERS)
    ) u_rr (
        .req_i   (bus.m_cs),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    // Pick the winning master's request fields and decode its slave.
    always_comb begin
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (rr_grant[i]) begin
                req_we    = bus.m_we[i];
                req_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
                req_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
            end
        end
        req_sel    = req_addr[SEL_LSB +: SEL_W];
        req_mapped = (int'(req_sel) < N_SLAVES);
    end

    // Only the selected slave's ready and read data are looked at.
    always_comb begin
        rd_data = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            if (s_cs_q[j]) begin
                rd_data = bus.s_rdata[j*DATA_W +: DATA_W];
            end
        end
        rd_hit = |(bus.s_rdy & s_cs_q);
    end

    assign ptr_next = (int'(gidx_q) == N_MASTERS - 1) ? '0 : gidx_q + PTR_W'(1);

    // Next-state and next-output logic of the arbiter FSM.
    // The error pulse is registered while leaving ERR, so it is visible in the
    // following IDLE cycle; IDLE does not grant while a pulse is on the bus, so
    // the finishing master has a cycle to drop m_cs before it could be regranted.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        s_cs_d    = s_cs_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_rdy_d   = '0;
        m_err_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (rr_valid && (m_rdy_q == '0)) begin
                    grant_d   = rr_grant;
                    gidx_d    = rr_idx;
                    s_we_d    = req_we;
                    s_addr_d  = req_addr;
                    s_wdata_d = req_wdata;
                    cnt_d     = '0;
                    if (req_mapped) begin
                        for (int j = 0; j < N_SLAVES; j++) begin
                            s_cs_d[j] = (int'(req_sel) == j);
                        end
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                if (rd_hit) begin
                    m_rdata_d = rd_data;
                    m_rdy_d   = grant_q;
                    s_cs_d    = '0;
                    state_d   = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    s_cs_d  = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                ptr_d   = ptr_next;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                m_rdy_d   = grant_q;
                m_err_d   = grant_q;
                m_rdata_d = '0;
                ptr_d     = ptr_next;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            s_cs_q    <= '0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_rdy_q   <= '0;
            m_err_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            s_cs_q    <= s_cs_d;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_rdy_q   <= m_rdy_d;
            m_err_q   <= m_err_d;
        end
    end

    assign bus.s_cs     = s_cs_q;
    assign bus.s_we     = s_we_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.m_rdata  = m_rdata_q;
    assign bus.m_rdy    = m_rdy_q;
    assign bus.m_err    = m_err_q;
    assign dbg_state_o  = state_q;
    assign dbg_ptr_o    = ptr_q;

endmodule

// File: tb/tb_limn2600_bus_arbiter.sv
// Directed bench for limn2600_bus_arbiter: a vector table of single
// transactions plus hand-written reset, reset-mid-access and contention
// sequences. Inputs change #1 after the rising edge, outputs are checked
// at the same point before new inputs are driven.
module tb_limn2600_bus_arbiter;
    import limn2600_bus_pkg::*;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic             clk;
    logic             rst;
    arb_state_e       dbg_state;
    logic [PTR_W-1:0] dbg_ptr;

    int n_cmp  = 0;
    int n_fail = 0;

    limn2600_bus_arbiter_if #(
        .N_MASTERS (NM), .N_SLAVES (NS), .DATA_W (DW), .ADDR_W (AW)
    ) bus ();

    limn2600_bus_arbiter #(
        .N_MASTERS (NM), .N_SLAVES (NS), .DATA_W (DW), .ADDR_W (AW), .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;     // data the slave returns
        int          k;         // cycle the slave raises s_rdy (0 = never)
        logic        noise;     // other slave raises s_rdy in cycle 1
        logic        chg;       // master changes its request fields in cycle 2
        logic        drop;      // master drops m_cs in cycle 2
        logic [1:0]  exp_scs;
        int          scs_last;  // last cycle s_cs is expected high
        int          done;      // cycle of the m_rdy pulse
        logic        err;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_ptr;
    } vec_t;

    vec_t tbl[7];
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_cs    = '0;
        bus.m_we    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.s_rdy   = '0;
        bus.s_rdata = '0;
    endtask

    // One transaction from a table entry; the current cycle is cycle 0.
    task automatic run_vec(input int id, input vec_t v);
        int         slv;
        logic [1:0] exp_m;
        logic [1:0] es;
        string      tag;
        slv   = v.exp_scs[1] ? 1 : 0;
        exp_m = (v.m == 1) ? 2'b10 : 2'b01;
        bus.m_cs[v.m]               = 1'b1;
        bus.m_we[v.m]               = v.we;
        bus.m_addr[v.m*32 +: 32]    = v.addr;
        bus.m_wdata[v.m*32 +: 32]   = v.wdata;
        for (int c = 1; c <= v.done + 1; c++) begin
            tick();
            tag = $sformatf("vec%0d c%0d", id, c);
            es  = (c <= v.scs_last) ? v.exp_scs : 2'b00;
            check({tag, " s_cs"}, 64'(bus.s_cs), 64'(es));
            if (c <= v.scs_last) begin
                check({tag, " s_we"}, 64'(bus.s_we), 64'(v.we));
                check({tag, " s_addr"}, 64'(bus.s_addr), 64'(v.addr));
                check({tag, " s_wdata"}, 64'(bus.s_wdata), 64'(v.wdata));
            end
            check({tag, " m_rdy"}, 64'(bus.m_rdy), 64'((c == v.done) ? exp_m : 2'b00));
            check({tag, " m_err"}, 64'(bus.m_err), 64'((c == v.done && v.err) ? exp_m : 2'b00));
            if (c == v.done) check({tag, " m_rdata"}, 64'(bus.m_rdata), 64'(v.exp_rdata));
            if (c == v.done + 1) check({tag, " ptr"}, 64'(dbg_ptr), 64'(v.exp_ptr));
            bus.s_rdy = '0;
            if (v.noise && c == 1) begin
                bus.s_rdy[1-slv]             = 1'b1;
                bus.s_rdata[(1-slv)*32 +: 32] = 32'hBAD0_BAD0;
            end
            if (v.k != 0 && c == v.k) begin
                bus.s_rdy[slv]            = 1'b1;
                bus.s_rdata[slv*32 +: 32] = v.rdata;
            end
            if (v.chg && c == 2) begin
                bus.m_we[v.m]             = ~v.we;
                bus.m_addr[v.m*32 +: 32]  = ~v.addr;
                bus.m_wdata[v.m*32 +: 32] = ~v.wdata;
            end
            if (v.drop && c == 2) bus.m_cs[v.m] = 1'b0;
            if (c == v.done) begin
                bus.m_cs[v.m]             = 1'b0;
                bus.m_we[v.m]             = 1'b0;
                bus.m_addr[v.m*32 +: 32]  = '0;
                bus.m_wdata[v.m*32 +: 32] = '0;
            end
        end
    endtask

    initial begin
        logic [1:0] e;
        logic [1:0] last_e;
        int         served;
        bit         pend;

        //             m  we    addr          wdata         rdata         k  nz    chg   drop  scs    last done err   exp_rdata     ptr
        tbl[0] = '{0, 1'b0, 32'h1000_0040, 32'h0000_0000, 32'hDEAD_BEEF, 3, 1'b1, 1'b0, 1'b0, 2'b10, 3, 4, 1'b0, 32'hDEAD_BEEF, 3'd1};
        tbl[1] = '{1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h5555_AAAA, 2, 1'b0, 1'b0, 1'b0, 2'b01, 2, 3, 1'b0, 32'h5555_AAAA, 3'd0};
        tbl[2] = '{0, 1'b0, 32'h1000_0000, 32'h0000_0000, 32'hA5A5_0001, 1, 1'b1, 1'b0, 1'b0, 2'b10, 1, 2, 1'b0, 32'hA5A5_0001, 3'd1};
        tbl[3] = '{1, 1'b0, 32'hF000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 2, 1'b1, 32'h0000_0000, 3'd0};
        tbl[4] = '{0, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 2'b01, 4, 6, 1'b1, 32'h0000_0000, 3'd1};
        tbl[5] = '{0, 1'b0, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 2, 1'b1, 32'h0000_0000, 3'd1};
        tbl[6] = '{1, 1'b1, 32'h1000_0020, 32'hCAFE_0006, 32'h0BAD_F00D, 4, 1'b0, 1'b1, 1'b1, 2'b10, 4, 5, 1'b0, 32'h0BAD_F00D, 3'd0};

        // Reset values.
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("reset s_cs", 64'(bus.s_cs), 64'(0));
        check("reset s_we", 64'(bus.s_we), 64'(0));
        check("reset s_addr", 64'(bus.s_addr), 64'(0));
        check("reset s_wdata", 64'(bus.s_wdata), 64'(0));
        check("reset m_rdata", 64'(bus.m_rdata), 64'(0));
        check("reset m_rdy", 64'(bus.m_rdy), 64'(0));
        check("reset m_err", 64'(bus.m_err), 64'(0));
        check("reset ptr", 64'(dbg_ptr), 64'(0));
        check("reset state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        tick();
        check("idle s_cs", 64'(bus.s_cs), 64'(0));
        check("idle m_rdy", 64'(bus.m_rdy), 64'(0));

        // Vector table.
        for (int i = 0; i < 7; i++) begin
            run_vec(i, tbl[i]);
        end

        // Reset in the middle of an access, pointer nonzero beforehand.
        run_vec(10, tbl[0]);
        bus.m_cs[1]          = 1'b1;
        bus.m_addr[32 +: 32] = 32'h1000_0000;
        tick();
        check("rstmid c1 s_cs", 64'(bus.s_cs), 64'(2'b10));
        tick();
        check("rstmid c2 s_cs", 64'(bus.s_cs), 64'(2'b10));
        check("rstmid c2 ptr", 64'(dbg_ptr), 64'(1));
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        check("rstmid c3 s_cs", 64'(bus.s_cs), 64'(0));
        check("rstmid c3 m_rdy", 64'(bus.m_rdy), 64'(0));
        check("rstmid c3 m_err", 64'(bus.m_err), 64'(0));
        check("rstmid c3 m_rdata", 64'(bus.m_rdata), 64'(0));
        check("rstmid c3 s_addr", 64'(bus.s_addr), 64'(0));
        check("rstmid c3 ptr", 64'(dbg_ptr), 64'(0));
        check("rstmid c3 state", 64'(dbg_state), 64'(ST_IDLE));
        bus.s_rdy[1]          = 1'b1;
        bus.s_rdata[32 +: 32] = 32'h7777_7777;
        tick();
        check("rstmid c4 m_rdy", 64'(bus.m_rdy), 64'(0));
        check("rstmid c4 s_cs", 64'(bus.s_cs), 64'(0));
        bus.s_rdy = '0;
        tick();
        check("rstmid c5 m_rdy", 64'(bus.m_rdy), 64'(0));
        check("rstmid c5 m_rdata", 64'(bus.m_rdata), 64'(0));

        // Contention: both masters request together, two rounds.
        exp_q  = '{2'b01, 2'b10, 2'b01, 2'b10};
        last_e = 2'b00;
        for (int r = 0; r < 2; r++) begin
            bus.m_cs    = 2'b11;
            bus.m_we    = 2'b00;
            bus.m_addr  = {32'h1000_0008, 32'h0000_0004};
            bus.s_rdata = {32'hC0DE_0001, 32'hC0DE_0000};
            served = 0;
            pend   = 1'b0;
            for (int c = 0; c < 30 && served < 2; c++) begin
                tick();
                if (pend) begin
                    check($sformatf("cont r%0d ptr", r), 64'(dbg_ptr), 64'((last_e == 2'b01) ? 1 : 0));
                    pend = 1'b0;
                end
                if (bus.s_cs != '0 && exp_q.size() > 0) begin
                    check($sformatf("cont r%0d s_cs", r), 64'(bus.s_cs), 64'(exp_q[0]));
                end
                if (bus.m_rdy != '0) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
                    check($sformatf("cont r%0d m_rdy", r), 64'(bus.m_rdy), 64'(e));
                    check($sformatf("cont r%0d m_err", r), 64'(bus.m_err), 64'(0));
                    check($sformatf("cont r%0d m_rdata", r), 64'(bus.m_rdata),
                          64'((e == 2'b01) ? 32'hC0DE_0000 : 32'hC0DE_0001));
                    bus.m_cs = bus.m_cs & ~e;
                    served++;
                    last_e = e;
                    pend   = 1'b1;
                end
                bus.s_rdy = bus.s_cs;
            end
            check($sformatf("cont r%0d served", r), 64'(served), 64'(2));
            bus.s_rdy = '0;
            bus.m_cs  = '0;
            if (pend) begin
                tick();
                check($sformatf("cont r%0d final ptr", r), 64'(dbg_ptr), 64'((last_e == 2'b01) ? 1 : 0));
            end
        end
        check("cont queue empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
